// File: rtl/qspi_rom_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | qspi_pkg                                                                   |
// | Shared constants and state encoding for the QSPI ROM read controller.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package qspi_pkg;

  localparam int ADDR_BITS_DEF = 24;
  localparam int CMD_LEN       = 8;
  localparam int ADDR_LEN      = ADDR_BITS_DEF / 4;
  localparam int DUMMY_LEN     = 6;

  localparam logic [7:0] CMD_READ = 8'hEB;

  // Flash edge index of the first data-nibble sample; the emulator bench uses it too.
  localparam int FIRST_NIBBLE_EDGE = CMD_LEN + ADDR_LEN + DUMMY_LEN;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_CMD    = 3'd1;
  localparam state_t ST_ADDR   = 3'd2;
  localparam state_t ST_DUMMY  = 3'd3;
  localparam state_t ST_STREAM = 3'd4;

  function automatic int first_nibble_edge(input int addr_bits, input int dummy);
    return CMD_LEN + addr_bits / 4 + dummy;
  endfunction

endpackage
`default_nettype wire

// File: rtl/qspi_rom_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | qspi_rom_ctrl_if                                                           |
// | CPU fetch request/response bus plus the QSPI pad signals.                  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface qspi_rom_ctrl_if #(
  parameter int ADDR_BITS = 24
);
  logic                 req_valid;
  logic [ADDR_BITS-1:0] req_addr;
  logic                 req_ready;
  logic                 rsp_valid;
  logic [7:0]           rsp_data;
  logic                 qspi_select;
  logic [3:0]           qspi_io_out;
  logic [3:0]           qspi_io_oe;
  logic [3:0]           qspi_io_in;

  modport slave (
    input  req_valid, req_addr, qspi_io_in,
    output req_ready, rsp_valid, rsp_data, qspi_select, qspi_io_out, qspi_io_oe
  );

  modport master (
    output req_valid, req_addr, qspi_io_in,
    input  req_ready, rsp_valid, rsp_data, qspi_select, qspi_io_out, qspi_io_oe
  );
endinterface
`default_nettype wire

// File: rtl/qspi_rom_ctrl_nibble_assembler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | qspi_nibble_assembler                                                      |
// | Pairs high/low data nibbles into bytes and tracks the streaming address.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module qspi_nibble_assembler
  import qspi_pkg::*;
#(
  parameter int ADDR_BITS = ADDR_BITS_DEF
) (
  input  wire logic                 clk,
  input  wire logic                 rst_n,
  input  wire logic                 load,
  input  wire logic [ADDR_BITS-1:0] load_addr,
  input  wire logic                 en,
  input  wire logic [3:0]           nibble,
  output logic                      byte_done,
  output logic [7:0]                byte_data,
  output logic [ADDR_BITS-1:0]      byte_addr
);

  logic                 r_have_hi;
  logic [3:0]           r_hi;
  logic [ADDR_BITS-1:0] r_stream_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_have_hi     <= 1'b0;
      r_hi          <= 4'h0;
      r_stream_addr <= '0;
    end else if (load) begin
      r_have_hi     <= 1'b0;
      r_stream_addr <= load_addr;
    end else if (en) begin
      if (r_have_hi) begin
        r_have_hi     <= 1'b0;
        r_stream_addr <= r_stream_addr + ADDR_BITS'(1);
      end else begin
        r_have_hi <= 1'b1;
        r_hi      <= nibble;
      end
    end
  end

  // The byte is presented combinationally on the low-nibble edge so the owner can
  // write its buffer on the very edge that samples the low nibble.
  assign byte_done = en & r_have_hi;
  assign byte_data = {r_hi, nibble};
  assign byte_addr = r_stream_addr;

endmodule
`default_nettype wire

// File: rtl/qspi_rom_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | qspi_rom_ctrl                                                              |
// | Quad-IO ROM read sequencer with a one-byte buffer and open-stream hits.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module qspi_rom_ctrl
  import qspi_pkg::*;
#(
  parameter int         ADDR_BITS    = qspi_pkg::ADDR_BITS_DEF,
  parameter int         DUMMY_CYCLES = qspi_pkg::DUMMY_LEN,
  parameter logic [7:0] CMD_READ     = qspi_pkg::CMD_READ
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  qspi_rom_ctrl_if.slave bus
);

  localparam int         c_addr_len     = ADDR_BITS / 4;
  localparam logic [4:0] c_cmd_last     = 5'(CMD_LEN - 1);
  localparam logic [4:0] c_addr_last    = 5'(CMD_LEN + c_addr_len - 1);
  localparam logic [4:0] c_stream_start = 5'(first_nibble_edge(ADDR_BITS, DUMMY_CYCLES));

  state_t               r_state;
  logic [4:0]           r_cnt;
  logic                 r_select;
  logic [3:0]           r_io_out;
  logic [3:0]           r_io_oe;
  logic                 r_pending;
  logic [ADDR_BITS-1:0] r_req_addr;
  logic [ADDR_BITS-1:0] r_addr_sh;
  logic                 r_rsp_valid;
  logic [7:0]           r_rsp_data;
  logic                 r_buf_valid;
  logic [ADDR_BITS-1:0] r_buf_addr;
  logic [7:0]           r_buf_data;

  logic                 w_byte_done;
  logic [7:0]           w_byte_data;
  logic [ADDR_BITS-1:0] w_byte_addr;
  logic [ADDR_BITS-1:0] w_next_addr;
  logic                 w_accept;
  logic                 w_buf_hit;
  logic                 w_stream_hit;
  logic [7:0]           w_hit_data;
  logic                 w_pend_done;

  qspi_nibble_assembler #(
    .ADDR_BITS (ADDR_BITS)
  ) u_asm (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (r_state == ST_DUMMY),
    .load_addr (r_req_addr),
    .en        (r_state == ST_STREAM),
    .nibble    (bus.qspi_io_in),
    .byte_done (w_byte_done),
    .byte_data (w_byte_data),
    .byte_addr (w_byte_addr)
  );

  // Lookups see the buffer and stream address as they will be after this edge.
  assign w_next_addr  = w_byte_done ? (w_byte_addr + ADDR_BITS'(1)) : w_byte_addr;
  assign w_buf_hit    = w_byte_done ? (w_byte_addr == bus.req_addr)
                                    : (r_buf_valid && (r_buf_addr == bus.req_addr));
  assign w_hit_data   = w_byte_done ? w_byte_data : r_buf_data;
  assign w_stream_hit = (r_state == ST_STREAM) && (w_next_addr == bus.req_addr);
  assign w_accept     = bus.req_valid & ~r_pending;
  assign w_pend_done  = r_pending & w_byte_done & (w_byte_addr == r_req_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 5'd0;
      r_select    <= 1'b1;
      r_io_out    <= 4'h0;
      r_io_oe     <= 4'h0;
      r_pending   <= 1'b0;
      r_req_addr  <= '0;
      r_addr_sh   <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 8'h00;
      r_buf_valid <= 1'b0;
      r_buf_addr  <= '0;
      r_buf_data  <= 8'h00;
    end else begin
      r_rsp_valid <= 1'b0;

      if (w_byte_done) begin
        r_buf_valid <= 1'b1;
        r_buf_addr  <= w_byte_addr;
        r_buf_data  <= w_byte_data;
      end

      if (w_pend_done) begin
        r_rsp_valid <= 1'b1;
        r_rsp_data  <= w_byte_data;
        r_pending   <= 1'b0;
      end

      // r_cnt is the index of the flash cycle whose value is launched at this edge.
      case (r_state)
        ST_CMD: begin
          r_select <= 1'b0;
          r_io_oe  <= 4'b0001;
          r_io_out <= {3'b000, CMD_READ[3'd7 - r_cnt[2:0]]};
          r_cnt    <= r_cnt + 5'd1;
          if (r_cnt == c_cmd_last) r_state <= ST_ADDR;
        end
        ST_ADDR: begin
          r_io_oe   <= 4'hF;
          r_io_out  <= r_addr_sh[ADDR_BITS-1 -: 4];
          r_addr_sh <= r_addr_sh << 4;
          r_cnt     <= r_cnt + 5'd1;
          if (r_cnt == c_addr_last) r_state <= ST_DUMMY;
        end
        ST_DUMMY: begin
          r_io_oe  <= 4'h0;
          r_io_out <= 4'h0;
          r_cnt    <= r_cnt + 5'd1;
          if (r_cnt == c_stream_start) r_state <= ST_STREAM;
        end
        default: begin
        end
      endcase

      if (w_accept) begin
        if (w_buf_hit) begin
          r_rsp_valid <= 1'b1;
          r_rsp_data  <= w_hit_data;
        end else if (w_stream_hit) begin
          r_pending  <= 1'b1;
          r_req_addr <= bus.req_addr;
        end else begin
          r_pending   <= 1'b1;
          r_req_addr  <= bus.req_addr;
          r_addr_sh   <= bus.req_addr;
          r_state     <= ST_CMD;
          r_cnt       <= 5'd0;
          r_select    <= 1'b1;
          r_io_oe     <= 4'h0;
          r_io_out    <= 4'h0;
          r_buf_valid <= 1'b0;
        end
      end
    end
  end

  assign bus.req_ready   = ~r_pending;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_data    = r_rsp_data;
  assign bus.qspi_select = r_select;
  assign bus.qspi_io_out = r_io_out;
  assign bus.qspi_io_oe  = r_io_oe;

endmodule
`default_nettype wire
